// File: rtl/adc_serdes_align_pkg.sv
// Shared types and helpers for the ISERDES word-alignment controller.
// Lane FSM encoding, counter sizing and the default training word.
package adc_serdes_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } lane_state_e;

  localparam logic [3:0] TRAIN_PATTERN_DEF = 4'b0011;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_serdes_bitslip_align_if.sv
// Lane data bundle between ISERDES capture and the CDC FIFO.
// master = data source/sink side, slave = alignment controller.
interface adc_serdes_bitslip_align_if #(
  parameter int NUM_LANES   = 32,
  parameter int DESER_WIDTH = 4
);

  logic [NUM_LANES*DESER_WIDTH-1:0] lane_data;
  logic [NUM_LANES*DESER_WIDTH-1:0] data_out;
  logic                             data_valid;

  modport master (
    output lane_data,
    input  data_out,
    input  data_valid
  );

  modport slave (
    input  lane_data,
    output data_out,
    output data_valid
  );

endinterface

// File: rtl/adc_serdes_align_lane.sv
// Per-lane bitslip alignment FSM.
// Slips until the lane shows the training word MATCH_COUNT times in a row.
module adc_serdes_align_lane
  import adc_serdes_align_pkg::*;
#(
  parameter int DESER_WIDTH = 4,
  parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN =
    DESER_WIDTH'(TRAIN_PATTERN_DEF),
  parameter int MATCH_COUNT = 16,
  parameter int SLIP_SETTLE = 3,
  parameter int MAX_SLIPS   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   train_start,
  input  logic [DESER_WIDTH-1:0] word,
  output logic                   bitslip,
  output logic                   locked,
  output logic                   failed,
  output logic                   locked_nxt,
  output logic                   busy_nxt
);

  localparam int MW = cnt_w(MATCH_COUNT);
  localparam int SW = cnt_w(MAX_SLIPS);
  localparam int WW = cnt_w(SLIP_SETTLE);

  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_SETTLE - 1);

  lane_state_e     state_q, state_d;
  logic [MW-1:0]   match_q, match_d;
  logic [SW-1:0]   slip_q, slip_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            bitslip_q, bitslip_d;

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    slip_d    = slip_q;
    wait_d    = wait_q;
    bitslip_d = 1'b0;
    // restart wins over everything, including a slip decided this cycle
    if (train_start) begin
      state_d = ST_CHECK;
      match_d = '0;
      slip_d  = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          match_d = '0;
          slip_d  = '0;
          wait_d  = '0;
        end
        ST_CHECK: begin
          if (word == TRAIN_PATTERN) begin
            match_d = match_q + MW'(1);
            if (match_q == MATCH_LAST) state_d = ST_LOCKED;
          end else begin
            match_d = '0;
            if (slip_q == SLIP_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d   = ST_SLIP;
              bitslip_d = 1'b1;
            end
          end
        end
        ST_SLIP: begin
          slip_d  = slip_q + SW'(1);
          wait_d  = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            state_d = ST_CHECK;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        ST_LOCKED, ST_FAIL: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      match_q   <= '0;
      slip_q    <= '0;
      wait_q    <= '0;
      bitslip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      wait_q    <= wait_d;
      bitslip_q <= bitslip_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = (state_q == ST_LOCKED);
  assign failed     = (state_q == ST_FAIL);
  assign locked_nxt = (state_d == ST_LOCKED);
  assign busy_nxt   = (state_d inside {ST_CHECK, ST_SLIP, ST_WAIT});

endmodule

// File: rtl/adc_serdes_bitslip_align.sv
// N-lane ISERDES word-alignment controller in the ADC CLKDIV domain.
// Registers lane data and reports aggregate lock/busy/done status.
module adc_serdes_bitslip_align
  import adc_serdes_align_pkg::*;
#(
  parameter int NUM_LANES   = 32,
  parameter int DESER_WIDTH = 4,
  parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN =
    DESER_WIDTH'(TRAIN_PATTERN_DEF),
  parameter int MATCH_COUNT = 16,
  parameter int SLIP_SETTLE = 3,
  parameter int MAX_SLIPS   = 8
) (
  input  logic                        adc_clk,
  input  logic                        ctrl_reset_n,
  input  logic                        train_start,
  adc_serdes_bitslip_align_if.slave   bus,
  output logic [NUM_LANES-1:0]        bitslip,
  output logic [NUM_LANES-1:0]        lane_locked,
  output logic [NUM_LANES-1:0]        lane_fail,
  output logic                        align_busy,
  output logic                        align_done
);

  localparam int DW = NUM_LANES * DESER_WIDTH;

  logic [NUM_LANES-1:0] lk_nxt;
  logic [NUM_LANES-1:0] bz_nxt;
  logic [DW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    adc_serdes_align_lane #(
      .DESER_WIDTH   (DESER_WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SLIP_SETTLE   (SLIP_SETTLE),
      .MAX_SLIPS     (MAX_SLIPS)
    ) u_lane (
      .clk         (adc_clk),
      .rst_n       (ctrl_reset_n),
      .train_start (train_start),
      .word        (bus.lane_data[k*DESER_WIDTH +: DESER_WIDTH]),
      .bitslip     (bitslip[k]),
      .locked      (lane_locked[k]),
      .failed      (lane_fail[k]),
      .locked_nxt  (lk_nxt[k]),
      .busy_nxt    (bz_nxt[k])
    );
  end

  // valid/busy track the lane next-states so they move with lane_locked
  always_comb begin
    data_d  = bus.lane_data;
    valid_d = &lk_nxt;
    busy_d  = |bz_nxt;
    done_d  = busy_q & ~busy_d;
  end

  always_ff @(posedge adc_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign align_busy     = busy_q;
  assign align_done     = done_q;

endmodule

// File: tb/tb_adc_serdes_bitslip_align.sv
// Directed bench for the bitslip aligner with a per-lane rotating
// ISERDES model driven from the bench's own word table.
module tb_adc_serdes_bitslip_align;

  localparam int NL = 32;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic train_start = 1'b0;
  logic [NL-1:0] bitslip;
  logic [NL-1:0] lane_locked;
  logic [NL-1:0] lane_fail;
  logic align_busy;
  logic align_done;

  adc_serdes_bitslip_align_if #(
    .NUM_LANES   (NL),
    .DESER_WIDTH (DW)
  ) bus ();

  adc_serdes_bitslip_align #(
    .NUM_LANES   (NL),
    .DESER_WIDTH (DW)
  ) dut (
    .adc_clk      (clk),
    .ctrl_reset_n (rst_n),
    .train_start  (train_start),
    .bus          (bus),
    .bitslip      (bitslip),
    .lane_locked  (lane_locked),
    .lane_fail    (lane_fail),
    .align_busy   (align_busy),
    .align_done   (align_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] word [NL];
  logic [NL-1:0] rot_en;

  always_comb begin
    bus.lane_data = '0;
    for (int k = 0; k < NL; k++)
      bus.lane_data[k*DW +: DW] = word[k];
  end

  typedef struct {
    logic [63:0] name;
    logic [3:0]  w5;
    logic [3:0]  w0;
    bit          rot;
    int          e_s5;
    int          e_s0;
    int          e_lat;
    logic [31:0] e_lock;
    logic [31:0] e_fail;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cur = 0;
  int cyc;
  int slips [NL];
  int lat_lk [NL];
  int lat_valid;
  int done_cnt;
  int last5;
  int spacing_bad;

  task automatic chk(input logic [63:0] nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %0s: got %0h want %0h",
               cur, nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    lat_valid = -1;
    done_cnt = 0;
    last5 = -1;
    spacing_bad = 0;
    for (int k = 0; k < NL; k++) begin
      slips[k] = 0;
      lat_lk[k] = -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NL; k++) begin
      if (bitslip[k]) begin
        slips[k]++;
        if (k == 5) begin
          if (last5 >= 0 && cyc - last5 != 5)
            spacing_bad++;
          last5 = cyc;
        end
        if (rot_en[k])
          word[k] = {word[k][DW-2:0], word[k][DW-1]};
      end
      if (lat_lk[k] < 0 && lane_locked[k])
        lat_lk[k] = cyc;
    end
    if (lat_valid < 0 && bus.data_valid)
      lat_valid = cyc;
    if (align_done)
      done_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    train_start = 1'b0;
    rot_en = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse();
    clear_stats();
    train_start = 1'b1;
    step();
    train_start = 1'b0;
  endtask

  initial begin
    vec_t v [5];
    int others;
    bit found;

    v[0] = '{"aligned", 4'h3, 4'h3, 1'b0, 0, 0, 17,
             32'hFFFF_FFFF, 32'h0};
    v[1] = '{"rot3", 4'h6, 4'h3, 1'b1, 3, 0, 32,
             32'hFFFF_FFFF, 32'h0};
    v[2] = '{"rot2", 4'hC, 4'h3, 1'b1, 2, 0, 27,
             32'hFFFF_FFFF, 32'h0};
    v[3] = '{"rot1", 4'h9, 4'h3, 1'b1, 1, 0, 22,
             32'hFFFF_FFFF, 32'h0};
    v[4] = '{"dead0", 4'h3, 4'h0, 1'b0, 0, 8, -1,
             32'hFFFF_FFFE, 32'h1};

    for (int k = 0; k < NL; k++) word[k] = 4'h3;
    rot_en = '0;
    clear_stats();

    #2 rst_n = 1'b0;
    #1;
    chk("rst_bs", bitslip, 0);
    chk("rst_lk", lane_locked, 0);
    chk("rst_fl", lane_fail, 0);
    chk("rst_vld", bus.data_valid, 0);
    chk("rst_dat", bus.data_out, 0);
    chk("rst_bsy", {align_busy, align_done}, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      cur = i + 1;
      do_reset();
      for (int k = 0; k < NL; k++) word[k] = 4'h3;
      word[5] = v[i].w5;
      word[0] = v[i].w0;
      rot_en = v[i].rot ? (32'd1 << 5) : 32'd0;
      pulse();
      repeat (60) step();
      others = 0;
      for (int k = 1; k < NL; k++)
        if (k != 5) others += slips[k];
      chk("slips5", slips[5], v[i].e_s5);
      chk("slips0", slips[0], v[i].e_s0);
      chk("slipsX", others, 0);
      chk("spacing", spacing_bad, 0);
      chk("lat_vld", lat_valid, v[i].e_lat);
      chk("lat_l1", lat_lk[1], 17);
      chk("locked", lane_locked, v[i].e_lock);
      chk("fail", lane_fail, v[i].e_fail);
      chk("done", done_cnt, 1);
      chk("busy", align_busy, 0);
      chk("dout", bus.data_out, bus.lane_data);
    end

    // glitch on the 16th training word of lane 7
    cur = 10;
    do_reset();
    for (int k = 0; k < NL; k++) word[k] = 4'h3;
    pulse();
    repeat (15) step();
    word[7] = 4'h0;
    step();
    word[7] = 4'h3;
    repeat (30) step();
    chk("g_slip7", slips[7], 1);
    chk("g_lat7", lat_lk[7], 37);
    chk("g_lat6", lat_lk[6], 17);
    chk("g_vld", lat_valid, 37);
    chk("g_done", done_cnt, 1);

    // registered data path and lock hold on odd data
    cur = 11;
    word[9] = 4'hA;
    #1;
    chk("d_old", bus.data_out[39:36], 4'h3);
    step();
    chk("d_new", bus.data_out[39:36], 4'hA);
    chk("d_lk", lane_locked, 32'hFFFF_FFFF);
    chk("d_vld", bus.data_valid, 1);
    word[9] = 4'h3;
    step();

    // retrain, then restart on the cycle lane 3 would slip
    cur = 12;
    word[3] = 4'h6;
    pulse();
    chk("r_lk", lane_locked, 0);
    chk("r_vld", bus.data_valid, 0);
    chk("r_bsy", align_busy, 1);
    train_start = 1'b1;
    step();
    train_start = 1'b0;
    word[3] = 4'h3;
    chk("r_sup", bitslip, 0);
    repeat (30) step();
    chk("r_slip3", slips[3], 0);
    chk("r_vlat", lat_valid, 18);
    chk("r_lk2", lane_locked, 32'hFFFF_FFFF);
    chk("r_done", done_cnt, 1);

    // async reset on a bitslip cycle
    cur = 13;
    do_reset();
    for (int k = 0; k < NL; k++) word[k] = 4'h3;
    word[0] = 4'h0;
    pulse();
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      step();
      if (bitslip[0] && cyc >= 20) found = 1'b1;
    end
    chk("x_seen", found, 1);
    chk("x_pre", lane_locked, 32'hFFFF_FFFE);
    rst_n = 1'b0;
    #1;
    chk("x_bs", bitslip, 0);
    chk("x_lk", lane_locked, 0);
    chk("x_vld", bus.data_valid, 0);
    chk("x_dat", bus.data_out, 0);
    chk("x_bsy", align_busy, 0);
    step();
    rst_n = 1'b1;
    clear_stats();
    repeat (10) step();
    chk("x_idle", align_busy, 0);
    chk("x_slip", slips[0], 0);
    chk("x_lk2", lane_locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
